adder_subtractor_bist: RTL
==========================

# adder_subtractor_bist

Synthesizable built-in self-test engine for the signed WIDTH-bit adder/subtractor. It sits on the initiator side of the adder's port list, driving pseudo-random operands and the add/subtract control into the adder. It samples the adder's result, carry-out and overflow, compares them against an internally computed expected value, and reports pass/fail with an error count and the index of the first failing vector. It allows the arithmetic block to be checked in silicon or on FPGA without a simulator.

## Interface
- WIDTH, 4, operand/result width; legal range 2..8.
- NUM_VECTORS, 100, vectors per run; legal range 1..65535.
- SETTLE_CYCLES, 2, cycles a vector is held before sampling; minimum 1.
- SEED, 16'hACE1, LFSR load value; must be nonzero.

- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  begin a run; honoured only in IDLE or DONE.
- x_out  output  WIDTH  operand x to the adder, equal to lfsr[WIDTH-1:0].
- y_out  output  WIDTH  operand y to the adder, equal to lfsr[15 -: WIDTH].
- control_out  output  1  1 selects subtract and 0 selects add; equal to lfsr[WIDTH].
- result_in  input  WIDTH  adder result.
- cout_in  input  1  adder carry-out.
- overflow_in  input  1  adder signed overflow.
- busy  output  1  high in APPLY and CHECK.
- done  output  1  high in DONE.
- pass  output  1  high in DONE when err_count == 0.
- err_count  output  16  mismatching vectors this run; saturates at 16'hFFFF.
- first_err_idx  output  16  index of the first mismatch; 16'hFFFF if there is none.
- vec_idx  output  16  index of the vector currently driven.

## Operation
- **LFSR:** 16-bit Galois, right shift.
  - Step rule: lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0).
  - The LFSR steps once per vector.
- **Expected value:**
  - ye = y ^ {WIDTH{c}}.
  - sum = {1'b0,x} + {1'b0,ye} + c, computed as a (WIDTH+1)-bit sum.
  - exp_result = sum[WIDTH-1:0].
  - exp_cout = sum[WIDTH].
  - exp_ovf = carry into bit WIDTH-1 XOR sum[WIDTH].
- **Mismatch:** any of result, cout or overflow differs from its expected value.
- **FSM states:** IDLE, APPLY, CHECK, DONE.
  - IDLE: when start is high, load lfsr <= SEED, vec_idx <= 0, err_count <= 0, first_err_idx <= 16'hFFFF and the settle counter to 0, then go to APPLY.
  - APPLY: hold the vector and increment the settle counter. After SETTLE_CYCLES cycles, go to CHECK.
  - CHECK: compare the sampled inputs against the expected value.
    - On mismatch: increment err_count (saturating). If first_err_idx == 16'hFFFF, load it with vec_idx.
    - If vec_idx == NUM_VECTORS-1, go to DONE. Otherwise step the LFSR, increment vec_idx, clear the settle counter and go to APPLY.
  - DONE: hold all results. When start is high, perform the same reload as in IDLE and go to APPLY.
- start is ignored in APPLY and CHECK.
- pass is computed combinationally as (state == DONE) && (err_count == 0).

## Timing
- **Reset values (rst_n low at a rising edge):**
  - state IDLE, lfsr = SEED, vec_idx 0.
  - err_count 0, first_err_idx 16'hFFFF.
  - busy 0, done 0, pass 0.
  - x_out, y_out and control_out show the SEED fields: for WIDTH=4, x=1, y=A, c=0.
- Reset applies at any time, including mid-run. The next cycle shows all reset values.
- Start latency: start is sampled high at edge T, and busy is high from T.
- Vector drive: each vector is driven for SETTLE_CYCLES+1 cycles, and the inputs are sampled at the edge that ends CHECK.
- Run length: done rises exactly NUM_VECTORS*(SETTLE_CYCLES+1) cycles after the start edge.
- The outputs change only at the CHECK-exit edge, at the same edge as the vec_idx change.
- err_count and first_err_idx update at the CHECK-exit edge and are stable in DONE.
- Simultaneous start and reset: reset wins.

## Test plan
- **Reset:** hold rst_n low for 3 cycles -> busy=0, done=0, pass=0, err_count=0, first_err_idx=FFFF, x_out=1, y_out=A, control_out=0.
- **Golden adder connected (WIDTH=4, NUM_VECTORS=100, SETTLE_CYCLES=2):**
  - Vector 0 is x=1, y=A, c=0, with expected result B, cout 0, overflow 0.
  - Vector 1 is x=0, y=E, c=1, with expected result 2, cout 0, overflow 0.
  - done rises 300 cycles after start, with pass=1, err_count=0 and first_err_idx=FFFF.
- **Fault injection, result bit0 always inverted:** done after 300 cycles with err_count=100 (0x64), first_err_idx=0, pass=0.
- **Fault only while vec_idx==5, cout inverted:** err_count=1, first_err_idx=5, pass=0.
- **Start behaviour:**
  - Pulse start during vector 20 -> no effect, and done still rises at cycle 300.
  - Pulse start in DONE -> vector 0 is again x=1, y=A, c=0, and the run reproduces identical results.
- **Reset mid-run:** assert rst_n low during vector 40 -> reset values appear on the next cycle. A fresh start then runs the full 100 vectors, ending in pass=1 with the golden adder.

Source files
------------

// File: rtl/adder_subtractor_bist.sv
// adder_subtractor_bist: built-in self-test engine for a signed WIDTH-bit
// adder/subtractor. Drives LFSR-derived operands and the add/subtract control,
// samples the adder's result/carry/overflow, and reports pass/fail, error count
// and the index of the first failing vector.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             begin a run (honoured in IDLE or DONE only)
//   x_out, y_out      operands to the adder (lfsr[WIDTH-1:0], lfsr[15 -: WIDTH])
//   control_out       1 = subtract, 0 = add (lfsr[WIDTH])
//   result_in, cout_in, overflow_in   adder responses
//   busy, done, pass  run status
//   err_count         mismatching vectors this run (saturating)
//   first_err_idx     first failing vector index, 16'hFFFF if none
//   vec_idx           index of the vector currently driven
module adder_subtractor_bist #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned NUM_VECTORS   = 100,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic             control_out,
    input  logic [WIDTH-1:0] result_in,
    input  logic             cout_in,
    input  logic             overflow_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [15:0]      first_err_idx,
    output logic [15:0]      vec_idx
);

    localparam int unsigned SET_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);
    localparam logic [15:0] NO_ERR   = 16'hFFFF;
    localparam logic [15:0] TAPS     = 16'hB400;

    typedef enum logic [1:0] {S_IDLE, S_APPLY, S_CHECK, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [15:0]        vec_idx_q, vec_idx_d;
    logic [15:0]        err_count_q, err_count_d;
    logic [15:0]        first_err_q, first_err_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Reference arithmetic for the vector currently driven
    logic [WIDTH-1:0]   op_ye;
    logic [WIDTH:0]     exp_sum;
    logic [WIDTH-1:0]   low_sum;
    logic               exp_ovf;
    logic               mismatch;

    assign x_out       = lfsr_q[WIDTH-1:0];
    assign y_out       = lfsr_q[15 -: WIDTH];
    assign control_out = lfsr_q[WIDTH];

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = done_q && (err_count_q == 16'h0000);
    assign err_count     = err_count_q;
    assign first_err_idx = first_err_q;
    assign vec_idx       = vec_idx_q;

    // Expected result/carry/overflow; overflow = carry into MSB xor carry out
    always_comb begin
        op_ye    = y_out ^ {WIDTH{control_out}};
        exp_sum  = {1'b0, x_out} + {1'b0, op_ye} + (WIDTH+1)'(control_out);
        low_sum  = {1'b0, x_out[WIDTH-2:0]} + {1'b0, op_ye[WIDTH-2:0]}
                 + WIDTH'(control_out);
        exp_ovf  = low_sum[WIDTH-1] ^ exp_sum[WIDTH];
        mismatch = (result_in != exp_sum[WIDTH-1:0]) ||
                   (cout_in != exp_sum[WIDTH]) ||
                   (overflow_in != exp_ovf);
    end

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        vec_idx_d   = vec_idx_q;
        err_count_d = err_count_q;
        first_err_d = first_err_q;
        settle_d    = settle_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    lfsr_d      = SEED;
                    vec_idx_d   = 16'h0000;
                    err_count_d = 16'h0000;
                    first_err_d = NO_ERR;
                    settle_d    = '0;
                    state_d     = S_APPLY;
                end
            end
            S_APPLY: begin
                settle_d = settle_q + SET_W'(1);
                if (settle_q == SETTLE_LAST) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    if (err_count_q != 16'hFFFF) begin
                        err_count_d = err_count_q + 16'h0001;
                    end
                    if (first_err_q == NO_ERR) begin
                        first_err_d = vec_idx_q;
                    end
                end
                if (vec_idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
                    vec_idx_d = vec_idx_q + 16'h0001;
                    settle_d  = '0;
                    state_d   = S_APPLY;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_APPLY) || (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lfsr_q      <= SEED;
            vec_idx_q   <= 16'h0000;
            err_count_q <= 16'h0000;
            first_err_q <= NO_ERR;
            settle_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            vec_idx_q   <= vec_idx_d;
            err_count_q <= err_count_d;
            first_err_q <= first_err_d;
            settle_q    <= settle_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule
